// File: rtl/hubris_dump_pkg.sv
// hubris_dump_pkg: shared state encoding and sizes for the memory dump streamer.
// Imported by mem_dump_streamer and mem_dump_fifo.
package hubris_dump_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        FINISH
    } dump_state_t;

    localparam int DUMP_WORD_WIDTH = 32;
    localparam int FIFO_DEPTH      = 2;
    localparam int FIFO_CNT_W      = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/mem_dump_fifo.sv
// mem_dump_fifo: 2-entry valid/ready FIFO carrying {last, word} beats.
// Storage and pointers clear asynchronously so the outputs read 0 in reset.
module mem_dump_fifo
    import hubris_dump_pkg::*;
#(
    parameter int WIDTH = DUMP_WORD_WIDTH + 1
) (
    input  logic                  clk,
    input  logic                  clear_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [FIFO_CNT_W-1:0] count
);

    logic [WIDTH-1:0] slots [FIFO_DEPTH];
    logic             wr_ptr;
    logic             rd_ptr;
    logic             push;
    logic             pop;

    assign in_ready  = (count != FIFO_CNT_W'(FIFO_DEPTH));
    assign out_valid = (count != '0);
    assign out_data  = slots[rd_ptr];
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Ring storage with a single occupancy counter.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                slots[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (push) begin
                slots[wr_ptr] <= in_data;
                wr_ptr        <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + FIFO_CNT_W'(push) - FIFO_CNT_W'(pop);
        end
    end

endmodule

// File: rtl/mem_dump_streamer.sv
// mem_dump_streamer: reads words 0..DEPTH_WORDS-1 and streams them out.
// Define MEM_DUMP_CHECKSUM_EN to append a mod-2**32 sum beat after the data.
module mem_dump_streamer
    import hubris_dump_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_WIDTH  = 10
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    output logic                       mem_rd_en,
    output logic [ADDR_WIDTH-1:0]      mem_rd_addr,
    input  logic [DUMP_WORD_WIDTH-1:0] mem_rd_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DUMP_WORD_WIDTH-1:0] out_data,
    output logic                       out_last,
    output logic                       busy,
    output logic                       done
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH_WORDS - 1);
    localparam logic [FIFO_CNT_W:0]   CAP       = (FIFO_CNT_W + 1)'(FIFO_DEPTH);

    dump_state_t                state;
    logic [ADDR_WIDTH-1:0]      addr;
    logic                       inflight;
    logic                       pending;
    logic [FIFO_CNT_W-1:0]      fifo_count;
    logic [FIFO_CNT_W:0]        occ;
    logic                       room;
    logic                       pop;
    logic                       push;
    logic                       fifo_ready;
    logic [DUMP_WORD_WIDTH:0]   push_data;

    assign pop         = out_valid && out_ready;
    assign occ         = {1'b0, fifo_count} + (FIFO_CNT_W + 1)'(pending);
    assign room        = occ < (CAP + (FIFO_CNT_W + 1)'(pop));
    assign mem_rd_en   = (state == READ) && room;
    assign mem_rd_addr = addr;

`ifdef MEM_DUMP_CHECKSUM_EN
    logic                       csum_pend;
    logic                       csum_issue;
    logic                       inflight_csum;
    logic [DUMP_WORD_WIDTH-1:0] csum;

    assign csum_issue = (state == DRAIN) && csum_pend && room;
    assign pending    = inflight || inflight_csum;
    assign push       = pending && fifo_ready;
    assign push_data  = inflight_csum ? {1'b1, csum} : {1'b0, mem_rd_data};

    // Sum returned words and schedule the sum as one extra pseudo-read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            csum          <= '0;
            csum_pend     <= 1'b0;
            inflight_csum <= 1'b0;
        end else begin
            inflight_csum <= csum_issue;
            if (state == IDLE) begin
                csum <= '0;
            end else if (inflight) begin
                csum <= csum + mem_rd_data;
            end
            if (mem_rd_en && addr == LAST_ADDR) begin
                csum_pend <= 1'b1;
            end else if (csum_issue) begin
                csum_pend <= 1'b0;
            end
        end
    end
`else
    logic inflight_last;

    assign pending   = inflight;
    assign push      = inflight && fifo_ready;
    assign push_data = {inflight_last, mem_rd_data};

    // Tag the read of the final address so its beat carries out_last.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inflight_last <= 1'b0;
        end else begin
            inflight_last <= mem_rd_en && (addr == LAST_ADDR);
        end
    end
`endif

    // Dump sequencer; a cleared inflight drops any read returning after reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            addr     <= '0;
            inflight <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            inflight <= mem_rd_en;
            done     <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state <= READ;
                        busy  <= 1'b1;
                    end
                end
                READ: begin
                    if (mem_rd_en) begin
                        if (addr == LAST_ADDR) begin
                            addr  <= '0;
                            state <= DRAIN;
                        end else begin
                            addr <= addr + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && out_last) begin
                        state <= FINISH;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    mem_dump_fifo #(
        .WIDTH(DUMP_WORD_WIDTH + 1)
    ) u_fifo (
        .clk      (clk),
        .clear_n  (reset),
        .in_valid (push),
        .in_ready (fifo_ready),
        .in_data  (push_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data ({out_last, out_data}),
        .count    (fifo_count)
    );

endmodule

// File: tb/tb_mem_dump_streamer.sv
// tb_mem_dump_streamer: directed bench for a 4-word dump.
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_mem_dump_streamer;

    localparam int DEPTH = 4;
    localparam int AW    = 2;
`ifdef MEM_DUMP_CHECKSUM_EN
    localparam int NB = 5;
`else
    localparam int NB = 4;
`endif

    logic          clk;
    logic          reset;
    logic          start;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [31:0]   mem_rd_data;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_data;
    logic          out_last;
    logic          busy;
    logic          done;

    logic [31:0] mem   [DEPTH];
    logic [31:0] exp_d [NB];
    logic [31:0] got_d [$];
    logic        got_l [$];
    int          rd_cnt;
    bit          done_seen;
    int          checks;
    int          errors;

    mem_dump_streamer #(
        .DEPTH_WORDS(DEPTH),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .mem_rd_en  (mem_rd_en),
        .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous memory: data valid the cycle after the strobe.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    end

    task automatic clear_log();
        got_d.delete();
        got_l.delete();
        rd_cnt    = 0;
        done_seen = 0;
    endtask

    task automatic tick(input logic rdy, input logic st);
        @(negedge clk);
        out_ready = rdy;
        start     = st;
        #1;
        if (mem_rd_en) rd_cnt++;
        if (out_valid && out_ready) begin
            got_d.push_back(out_data);
            got_l.push_back(out_last);
        end
        if (done) done_seen = 1;
    endtask

    task automatic run_until_done(input int mode, input int budget);
        for (int i = 0; i < budget && !done_seen; i++) begin
            tick((mode == 0) ? 1'b1 : ((i % 2) == 0), 1'b0);
        end
        checks++;
        if (!done_seen) begin
            errors++;
            $display("FAIL dump_timeout done not seen within %0d cycles", budget);
        end
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        start     = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({mem_rd_en, mem_rd_addr, out_valid, out_last, busy, done} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 0",
                     {mem_rd_en, mem_rd_addr, out_valid, out_last, busy, done});
        end
        checks++;
        if (out_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_data got %h want 0", out_data);
        end
        @(negedge clk);
        reset = 1'b1;
        tick(1'b1, 1'b0);
        checks++;
        if (mem_rd_en !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_quiet rd_en=%b busy=%b want 0 0", mem_rd_en, busy);
        end
    endtask

    task automatic test_latency();
        clear_log();
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b0);
        checks++;
        if (mem_rd_en !== 1'b1 || mem_rd_addr !== 2'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL lat_t1 rd_en=%b addr=%0d busy=%b want 1 0 1",
                     mem_rd_en, mem_rd_addr, busy);
        end
        tick(1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b0 || mem_rd_en !== 1'b1 || mem_rd_addr !== 2'd1) begin
            errors++;
            $display("FAIL lat_t2 valid=%b rd_en=%b addr=%0d want 0 1 1",
                     out_valid, mem_rd_en, mem_rd_addr);
        end
        for (int k = 0; k < NB; k++) begin
            tick(1'b1, 1'b0);
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_d[k] || out_last !== (k == NB - 1)) begin
                errors++;
                $display("FAIL lat_beat%0d got v=%b d=%h l=%b want 1 %h %b",
                         k, out_valid, out_data, out_last, exp_d[k], (k == NB - 1));
            end
        end
        tick(1'b1, 1'b0);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL lat_done done=%b busy=%b valid=%b want 1 0 0", done, busy, out_valid);
        end
        tick(1'b1, 1'b0);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse got %b want 0", done);
        end
    endtask

    task automatic test_backpressure();
        clear_log();
        tick(1'b0, 1'b1);
        for (int i = 1; i <= 10; i++) begin
            tick(1'b0, 1'b0);
            if (i >= 3) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== 32'h11111111) begin
                    errors++;
                    $display("FAIL bp_hold%0d got v=%b d=%h want 1 11111111",
                             i, out_valid, out_data);
                end
            end
        end
        checks++;
        if (rd_cnt !== 2 || mem_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL bp_reads got %0d rd_en=%b want 2 0", rd_cnt, mem_rd_en);
        end
        run_until_done(0, 40);
        checks++;
        if (got_d.size() !== NB) begin
            errors++;
            $display("FAIL bp_count got %0d want %0d", got_d.size(), NB);
        end
        for (int k = 0; k < got_d.size() && k < NB; k++) begin
            checks++;
            if (got_d[k] !== exp_d[k] || got_l[k] !== (k == NB - 1)) begin
                errors++;
                $display("FAIL bp_beat%0d got %h/%b want %h/%b",
                         k, got_d[k], got_l[k], exp_d[k], (k == NB - 1));
            end
        end
    endtask

    task automatic test_toggle();
        int nlast;
        clear_log();
        tick(1'b1, 1'b1);
        run_until_done(1, 60);
        nlast = 0;
        foreach (got_l[k]) nlast += int'(got_l[k]);
        checks++;
        if (got_d.size() !== NB || nlast !== 1) begin
            errors++;
            $display("FAIL tog_count beats=%0d lasts=%0d want %0d 1", got_d.size(), nlast, NB);
        end
        for (int k = 0; k < got_d.size() && k < NB; k++) begin
            checks++;
            if (got_d[k] !== exp_d[k] || got_l[k] !== (k == NB - 1)) begin
                errors++;
                $display("FAIL tog_beat%0d got %h/%b want %h/%b",
                         k, got_d[k], got_l[k], exp_d[k], (k == NB - 1));
            end
        end
    endtask

    task automatic test_reset_mid();
        clear_log();
        tick(1'b1, 1'b1);
        for (int i = 0; i < 20 && got_d.size() < 2; i++) tick(1'b1, 1'b0);
        checks++;
        if (got_d.size() !== 2) begin
            errors++;
            $display("FAIL rst_mid_pre got %0d beats want 2", got_d.size());
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if ({mem_rd_en, mem_rd_addr, out_valid, out_data, out_last, busy, done} !== '0) begin
            errors++;
            $display("FAIL rst_mid_out got en=%b a=%0d v=%b d=%h l=%b b=%b dn=%b want 0",
                     mem_rd_en, mem_rd_addr, out_valid, out_data, out_last, busy, done);
        end
        tick(1'b1, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) tick(1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_stale valid=%b busy=%b want 0 0", out_valid, busy);
        end
        clear_log();
        tick(1'b1, 1'b1);
        run_until_done(0, 30);
        checks++;
        if (got_d.size() !== NB) begin
            errors++;
            $display("FAIL rst_redump_count got %0d want %0d", got_d.size(), NB);
        end
        for (int k = 0; k < got_d.size() && k < NB; k++) begin
            checks++;
            if (got_d[k] !== exp_d[k] || got_l[k] !== (k == NB - 1)) begin
                errors++;
                $display("FAIL rst_redump_beat%0d got %h/%b want %h/%b",
                         k, got_d[k], got_l[k], exp_d[k], (k == NB - 1));
            end
        end
    endtask

    task automatic test_restart_ignored();
        clear_log();
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b1);
        run_until_done(0, 30);
        repeat (6) tick(1'b1, 1'b0);
        checks++;
        if (got_d.size() !== NB || rd_cnt !== DEPTH) begin
            errors++;
            $display("FAIL restart_count beats=%0d reads=%0d want %0d %0d",
                     got_d.size(), rd_cnt, NB, DEPTH);
        end
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL restart_idle busy=%b valid=%b want 0 0", busy, out_valid);
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        mem_rd_data = '0;
        mem[0] = 32'h11111111;
        mem[1] = 32'h22222222;
        mem[2] = 32'h33333333;
        mem[3] = 32'h44444444;
        for (int k = 0; k < DEPTH; k++) exp_d[k] = mem[k];
`ifdef MEM_DUMP_CHECKSUM_EN
        exp_d[4] = 32'hAAAAAAAA;
`endif
        test_reset();
        test_latency();
        test_backpressure();
        test_toggle();
        test_reset_mid();
        test_restart_ignored();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
